// File: rtl/usb_ep_pkg.sv
// Shared definitions for the USB endpoint bridge.
// Holds data/length widths, the pointer-width helper and the per-FIFO pointer set.
package usb_ep_pkg;

  localparam int unsigned EP_DATA_W = 8;
  localparam int unsigned LEN_W     = 12;
  // Storage width of every pointer. Counts are taken modulo 2^ptr_w(depth), which divides
  // 2^PTR_MAX_W, so free-running wide pointers still give exact counts.
  localparam int unsigned PTR_MAX_W = 16;

  // Count width for a FIFO of the given depth: one extra bit to tell full from empty.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic [PTR_MAX_W-1:0] commit_wr;
    logic [PTR_MAX_W-1:0] commit_rd;
    logic [PTR_MAX_W-1:0] spec;
  } ptr_set_t;

endpackage

// File: rtl/usb_ep_pkt_fifo.sv
// Byte FIFO with packet-level commit/rollback on the USB side.
//   UsbWrites=1 (OUT): USB writes speculatively at spec, commit_i publishes, rollback_i
//                      discards; user reads committed data.
//   UsbWrites=0 (IN):  user writes committed data; USB reads speculatively at spec,
//                      commit_i frees the read bytes, rollback_i rewinds for a retry.
// Ports: clk_i/rst_ni, flush_i (sync clear), wr_i/wr_data_i, rd_i/rd_data_o (FWFT head,
// 0 when empty), commit_i, rollback_i, len_o (OUT: min(free,MaxPkt), IN: min(count,MaxPkt)),
// full_o, empty_o (no committed data).
module usb_ep_pkt_fifo
  import usb_ep_pkg::*;
#(
  parameter int unsigned Depth     = 1024,
  parameter int unsigned MaxPkt    = 512,
  parameter bit          UsbWrites = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 wr_i,
  input  logic [EP_DATA_W-1:0] wr_data_i,
  input  logic                 rd_i,
  output logic [EP_DATA_W-1:0] rd_data_o,
  input  logic                 commit_i,
  input  logic                 rollback_i,
  output logic [LEN_W-1:0]     len_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned PtrW  = ptr_w(Depth);
  localparam int unsigned AddrW = PtrW - 1;

  typedef logic [PtrW-1:0]      cnt_t;
  typedef logic [PTR_MAX_W-1:0] uptr_t;

  logic [EP_DATA_W-1:0] mem_q [Depth];
  ptr_set_t ptr_q, ptr_d;
  logic     ovf_q, ovf_d;

  uptr_t cwr, crd, spc, cwr_nx, crd_nx, spc_nx, wr_ptr, rd_ptr;
  cnt_t  count, inflight;
  logic  full, wr_en, rd_en;
  logic [31:0] avail, offered;

  assign cwr      = ptr_q.commit_wr;
  assign crd      = ptr_q.commit_rd;
  assign spc      = ptr_q.spec;
  assign count    = cnt_t'(cwr - crd);
  // OUT: bytes held incl. the packet in flight. IN: bytes already popped this packet.
  assign inflight = cnt_t'(spc - crd);

  always_comb begin
    ovf_d   = ovf_q;
    full    = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_ptr  = cwr;
    rd_ptr  = crd;
    avail   = '0;
    offered = '0;
    cwr_nx  = cwr;
    crd_nx  = crd;
    spc_nx  = spc;
    if (UsbWrites) begin
      full    = (inflight == cnt_t'(Depth));
      wr_ptr  = spc;
      rd_ptr  = crd;
      wr_en   = wr_i && !full;
      rd_en   = rd_i && (count != '0);
      avail   = Depth - 32'(inflight);
      offered = (avail > MaxPkt) ? MaxPkt : avail;
      if (wr_i && full) ovf_d = 1'b1;
      spc_nx = spc + uptr_t'(wr_en);
      crd_nx = crd + uptr_t'(rd_en);
      // A packet that lost a byte is never published; the rxact fall discards it.
      if (commit_i && !ovf_d) begin
        cwr_nx = spc_nx;
      end else if (rollback_i) begin
        spc_nx = cwr;
        ovf_d  = 1'b0;
      end
    end else begin
      full    = (count == cnt_t'(Depth));
      wr_ptr  = cwr;
      rd_ptr  = spc;
      avail   = 32'(count);
      offered = (avail > MaxPkt) ? MaxPkt : avail;
      wr_en   = wr_i && !full;
      rd_en   = rd_i && (32'(inflight) < offered);
      cwr_nx  = cwr + uptr_t'(wr_en);
      spc_nx  = spc + uptr_t'(rd_en);
      if (commit_i) begin
        crd_nx = spc_nx;
      end else if (rollback_i) begin
        spc_nx = crd;
      end
    end
    if (flush_i) begin
      wr_en  = 1'b0;
      ovf_d  = 1'b0;
      cwr_nx = '0;
      crd_nx = '0;
      spc_nx = '0;
    end
    ptr_d.commit_wr = cwr_nx;
    ptr_d.commit_rd = crd_nx;
    ptr_d.spec      = spc_nx;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr[AddrW-1:0]] <= wr_data_i;
  end

  assign empty_o   = (count == '0);
  assign full_o    = full;
  assign len_o     = LEN_W'(offered);
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr[AddrW-1:0]];

endmodule

// File: rtl/usb_ep_bridge.sv
// Multi-endpoint bridge between the USB controller byte-stream endpoint interface and
// NUM_EP user channels, plus the interface alternate-setting register bank.
// Ports: controller side (endpt_i, rx*, tx*), alt bank (inf_*), user side per channel
// (in_wr_i/in_data_i/in_full_o, out_rd_i/out_data_o/out_empty_o). Endpoint k+1 maps to
// channel k; ep0 and endpoints above NUM_EP are unmapped and see NAK/not-ready.
module usb_ep_bridge
  import usb_ep_pkg::*;
#(
  parameter int unsigned NUM_EP     = 4,
  parameter int unsigned FIFO_DEPTH = 1024,
  parameter int unsigned MAX_PKT    = 512,
  parameter int unsigned NUM_INF    = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    usbrst_i,
  input  logic [3:0]              endpt_i,
  input  logic                    rxact_i,
  input  logic                    rxval_i,
  input  logic [7:0]              rxdat_i,
  input  logic                    rxpktval_i,
  output logic                    rxrdy_o,
  input  logic                    txact_i,
  input  logic                    txpop_i,
  input  logic                    txpktfin_i,
  output logic                    txcork_o,
  output logic [11:0]             txdat_len_o,
  output logic [7:0]              txdat_o,
  input  logic [7:0]              inf_sel_i,
  input  logic                    inf_set_i,
  input  logic [7:0]              inf_alter_i,
  output logic [7:0]              inf_alter_o,
  input  logic [NUM_EP-1:0]       in_wr_i,
  input  logic [8*NUM_EP-1:0]     in_data_i,
  output logic [NUM_EP-1:0]       in_full_o,
  input  logic [NUM_EP-1:0]       out_rd_i,
  output logic [8*NUM_EP-1:0]     out_data_o,
  output logic [NUM_EP-1:0]       out_empty_o
);

  logic                 rxact_q, txact_q;
  logic                 rx_fall, tx_fall;
  logic [NUM_EP-1:0]    ep_sel;
  logic [NUM_EP-1:0]    out_full, in_empty;
  logic [LEN_W-1:0]     out_len [NUM_EP];
  logic [LEN_W-1:0]     in_len  [NUM_EP];
  logic [EP_DATA_W-1:0] tx_data [NUM_EP];
  logic [7:0]           alt_q   [NUM_INF];
  logic [7:0]           alt_d   [NUM_INF];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rxact_q <= 1'b0;
      txact_q <= 1'b0;
    end else if (usbrst_i) begin
      rxact_q <= 1'b0;
      txact_q <= 1'b0;
    end else begin
      rxact_q <= rxact_i;
      txact_q <= txact_i;
    end
  end

  // Rollbacks go to every FIFO: only the addressed one can hold an uncommitted packet,
  // and after a commit spec equals the committed pointer, so the rest are no-ops.
  assign rx_fall = rxact_q && !rxact_i;
  assign tx_fall = txact_q && !txact_i;

  for (genvar k = 0; k < NUM_EP; k++) begin : g_ep
    assign ep_sel[k] = (endpt_i == 4'(k + 1));

    usb_ep_pkt_fifo #(
      .Depth     (FIFO_DEPTH),
      .MaxPkt    (MAX_PKT),
      .UsbWrites (1'b1)
    ) u_out (
      .clk_i      (clk_i),
      .rst_ni     (rst_n_i),
      .flush_i    (usbrst_i),
      .wr_i       (rxval_i && ep_sel[k]),
      .wr_data_i  (rxdat_i),
      .rd_i       (out_rd_i[k]),
      .rd_data_o  (out_data_o[8*k +: 8]),
      .commit_i   (rxpktval_i && ep_sel[k]),
      .rollback_i (rx_fall),
      .len_o      (out_len[k]),
      .full_o     (out_full[k]),
      .empty_o    (out_empty_o[k])
    );

    usb_ep_pkt_fifo #(
      .Depth     (FIFO_DEPTH),
      .MaxPkt    (MAX_PKT),
      .UsbWrites (1'b0)
    ) u_in (
      .clk_i      (clk_i),
      .rst_ni     (rst_n_i),
      .flush_i    (usbrst_i),
      .wr_i       (in_wr_i[k]),
      .wr_data_i  (in_data_i[8*k +: 8]),
      .rd_i       (txpop_i && ep_sel[k]),
      .rd_data_o  (tx_data[k]),
      .commit_i   (txpktfin_i && ep_sel[k]),
      .rollback_i (tx_fall),
      .len_o      (in_len[k]),
      .full_o     (in_full_o[k]),
      .empty_o    (in_empty[k])
    );
  end

  always_comb begin
    rxrdy_o     = 1'b0;
    txcork_o    = 1'b1;
    txdat_len_o = '0;
    txdat_o     = '0;
    for (int k = 0; k < NUM_EP; k++) begin
      if (ep_sel[k]) begin
        // len saturates at MAX_PKT, so equality means free space >= MAX_PKT.
        rxrdy_o     = !out_full[k] && (out_len[k] == LEN_W'(MAX_PKT));
        txcork_o    = in_empty[k];
        txdat_len_o = in_len[k];
        txdat_o     = tx_data[k];
      end
    end
  end

  always_comb begin
    inf_alter_o = '0;
    for (int k = 0; k < NUM_INF; k++) begin
      alt_d[k] = alt_q[k];
      if (inf_set_i && (inf_sel_i == 8'(k))) alt_d[k] = inf_alter_i;
      if (inf_sel_i == 8'(k)) inf_alter_o = alt_q[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < NUM_INF; k++) alt_q[k] <= '0;
    end else if (usbrst_i) begin
      for (int k = 0; k < NUM_INF; k++) alt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_INF; k++) alt_q[k] <= alt_d[k];
    end
  end

endmodule

// File: tb/tb_usb_ep_bridge.sv
// Self-checking bench for usb_ep_bridge: OUT bytes go to a scoreboard queue when a good
// packet is driven and are popped as the user reads; IN bytes are queued on user push and
// compared against txdat_o as the controller pops, with rewind on retry.
module tb_usb_ep_bridge;

  localparam int NUM_EP     = 4;
  localparam int FIFO_DEPTH = 1024;
  localparam int MAX_PKT    = 512;
  localparam int NUM_INF    = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  usbrst = 1'b0;
  logic [3:0]            endpt = '0;
  logic                  rxact = 1'b0, rxval = 1'b0, rxpktval = 1'b0;
  logic [7:0]            rxdat = '0;
  logic                  rxrdy;
  logic                  txact = 1'b0, txpop = 1'b0, txpktfin = 1'b0;
  logic                  txcork;
  logic [11:0]           txlen;
  logic [7:0]            txdat;
  logic [7:0]            inf_sel = '0, inf_alter_in = '0, inf_alter;
  logic                  inf_set = 1'b0;
  logic [NUM_EP-1:0]     in_wr = '0, in_full, out_rd = '0, out_empty;
  logic [8*NUM_EP-1:0]   in_data = '0, out_data;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] out_q [$];
  logic [7:0] in_q [$];
  int rd_idx = 0;

  always #5 clk = ~clk;

  usb_ep_bridge #(
    .NUM_EP     (NUM_EP),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_PKT    (MAX_PKT),
    .NUM_INF    (NUM_INF)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .usbrst_i    (usbrst),
    .endpt_i     (endpt),
    .rxact_i     (rxact),
    .rxval_i     (rxval),
    .rxdat_i     (rxdat),
    .rxpktval_i  (rxpktval),
    .rxrdy_o     (rxrdy),
    .txact_i     (txact),
    .txpop_i     (txpop),
    .txpktfin_i  (txpktfin),
    .txcork_o    (txcork),
    .txdat_len_o (txlen),
    .txdat_o     (txdat),
    .inf_sel_i   (inf_sel),
    .inf_set_i   (inf_set),
    .inf_alter_i (inf_alter_in),
    .inf_alter_o (inf_alter),
    .in_wr_i     (in_wr),
    .in_data_i   (in_data),
    .in_full_o   (in_full),
    .out_rd_i    (out_rd),
    .out_data_o  (out_data),
    .out_empty_o (out_empty)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic out_pkt(input int ep, input int n, input int base, input bit good);
    endpt = 4'(ep);
    rxact = 1'b1;
    step();
    for (int i = 0; i < n; i++) begin
      rxval = 1'b1;
      rxdat = 8'(base + i);
      if (good) out_q.push_back(8'(base + i));
      step();
    end
    rxval = 1'b0;
    chk("rxrdy_in_pkt", 32'(rxrdy), 32'd1);
    if (good) begin
      chk("out_empty_before_commit", 32'(out_empty[ep-1]), 32'd1);
      rxpktval = 1'b1;
      step();
      rxpktval = 1'b0;
      chk("out_empty_after_commit", 32'(out_empty[ep-1]), 32'd0);
    end
    rxact = 1'b0;
    step();
  endtask

  task automatic read_out(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      chk("out_data", 32'(out_data[8*ch +: 8]), 32'(out_q.pop_front()));
      out_rd[ch] = 1'b1;
      step();
      out_rd[ch] = 1'b0;
    end
    chk("out_empty_drained", 32'(out_empty[ch]), 32'd1);
  endtask

  task automatic push_in(input int ch, input int n, input int mul);
    for (int i = 0; i < n; i++) begin
      in_wr[ch] = 1'b1;
      in_data[8*ch +: 8] = 8'(i * mul + 1);
      in_q.push_back(8'(i * mul + 1));
      step();
    end
    in_wr[ch] = 1'b0;
  endtask

  // Pops n bytes checking each head, then optionally one extra pop past the offer.
  task automatic pop_in(input int n, input bit extra);
    txpop = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk("txdat", 32'(txdat), 32'(in_q[rd_idx]));
      rd_idx++;
      step();
    end
    if (extra) step();
    txpop = 1'b0;
  endtask

  task automatic fin();
    logic [7:0] d;
    txpktfin = 1'b1;
    step();
    txpktfin = 1'b0;
    for (int i = 0; i < rd_idx; i++) d = in_q.pop_front();
    rd_idx = 0;
  endtask

  task automatic tx_end();
    txact = 1'b0;
    step();
    rd_idx = 0;
  endtask

  initial begin
    // Reset values, checked while reset is held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rxrdy", 32'(rxrdy), 32'd0);
    chk("rst_txcork", 32'(txcork), 32'd1);
    chk("rst_txlen", 32'(txlen), 32'd0);
    chk("rst_txdat", 32'(txdat), 32'd0);
    chk("rst_in_full", 32'(in_full), 32'd0);
    chk("rst_out_empty", 32'(out_empty), 32'hF);
    chk("rst_alter", 32'(inf_alter), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // OUT on ep2, 64 bytes.
    out_pkt(2, 64, 0, 1'b1);
    chk("rxrdy_after_pkt", 32'(rxrdy), 32'd1);
    read_out(1, 64);

    // OUT on ep1: aborted 10-byte packet then a good 4-byte one.
    out_pkt(1, 10, 8'h40, 1'b0);
    chk("out_empty_after_abort", 32'(out_empty[0]), 32'd1);
    out_pkt(1, 4, 8'hA0, 1'b1);
    read_out(0, 4);

    // IN on ep3: 700 bytes, 512-byte packet acked, then 188-byte packet retried.
    push_in(2, 700, 1);
    endpt = 4'd3;
    #1;
    chk("ep3_len_700", 32'(txlen), 32'd512);
    chk("ep3_cork_700", 32'(txcork), 32'd0);
    txact = 1'b1;
    step();
    pop_in(512, 1'b1);
    chk("ep3_head_after_512", 32'(txdat), 32'(in_q[512]));
    fin();
    tx_end();
    chk("ep3_len_188", 32'(txlen), 32'd188);
    txact = 1'b1;
    step();
    pop_in(188, 1'b0);
    tx_end();
    chk("ep3_len_retry", 32'(txlen), 32'd188);
    chk("ep3_head_retry", 32'(txdat), 32'(in_q[0]));
    txact = 1'b1;
    step();
    pop_in(188, 1'b0);
    fin();
    tx_end();
    chk("ep3_cork_drained", 32'(txcork), 32'd1);
    chk("ep3_len_drained", 32'(txlen), 32'd0);

    // IN on ep1: fill to depth; full tracks the committed read pointer.
    push_in(0, FIFO_DEPTH, 3);
    chk("ep1_full", 32'(in_full[0]), 32'd1);
    in_wr[0] = 1'b1;
    in_data[7:0] = 8'h55;
    step();
    in_wr[0] = 1'b0;
    endpt = 4'd1;
    txact = 1'b1;
    step();
    pop_in(512, 1'b0);
    chk("ep1_full_unacked", 32'(in_full[0]), 32'd1);
    fin();
    chk("ep1_full_acked", 32'(in_full[0]), 32'd0);
    tx_end();
    chk("ep1_len_after_ack", 32'(txlen), 32'd512);
    chk("ep1_head_after_ack", 32'(txdat), 32'(in_q[0]));

    // Unmapped endpoints: no status, no FIFO effect.
    for (int e = 0; e <= NUM_EP + 1; e += NUM_EP + 1) begin
      endpt = 4'(e);
      #1;
      chk("unmapped_rxrdy", 32'(rxrdy), 32'd0);
      chk("unmapped_cork", 32'(txcork), 32'd1);
      chk("unmapped_len", 32'(txlen), 32'd0);
      rxact = 1'b1;
      txact = 1'b1;
      step();
      rxval = 1'b1;
      rxdat = 8'h77;
      txpop = 1'b1;
      repeat (3) step();
      rxval = 1'b0;
      txpop = 1'b0;
      rxpktval = 1'b1;
      txpktfin = 1'b1;
      step();
      rxpktval = 1'b0;
      txpktfin = 1'b0;
      rxact = 1'b0;
      txact = 1'b0;
      step();
      chk("unmapped_out_empty", 32'(out_empty), 32'hF);
    end
    endpt = 4'd1;
    #1;
    chk("ep1_len_untouched", 32'(txlen), 32'd512);
    chk("ep1_head_untouched", 32'(txdat), 32'(in_q[0]));

    // Alternate-setting bank.
    inf_sel = 8'd2;
    inf_alter_in = 8'd3;
    inf_set = 1'b1;
    step();
    inf_set = 1'b0;
    chk("alt_sel2", 32'(inf_alter), 32'd3);
    inf_sel = 8'd1;
    #1;
    chk("alt_sel1", 32'(inf_alter), 32'd0);
    inf_sel = 8'(NUM_INF);
    inf_alter_in = 8'd7;
    inf_set = 1'b1;
    step();
    inf_set = 1'b0;
    chk("alt_out_of_range", 32'(inf_alter), 32'd0);
    inf_sel = 8'd0;
    #1;
    chk("alt_no_alias", 32'(inf_alter), 32'd0);

    // USB bus reset.
    inf_sel = 8'd2;
    usbrst = 1'b1;
    step();
    usbrst = 1'b0;
    chk("usbrst_alter", 32'(inf_alter), 32'd0);
    chk("usbrst_out_empty", 32'(out_empty), 32'hF);
    chk("usbrst_cork", 32'(txcork), 32'd1);
    chk("usbrst_len", 32'(txlen), 32'd0);
    chk("usbrst_in_full", 32'(in_full), 32'd0);
    in_q.delete();
    rd_idx = 0;

    // Asynchronous reset in the middle of an OUT packet.
    inf_sel = 8'd0;
    inf_alter_in = 8'd9;
    inf_set = 1'b1;
    step();
    inf_set = 1'b0;
    chk("alt_sel0_set", 32'(inf_alter), 32'd9);
    push_in(0, 5, 1);
    endpt = 4'd1;
    rxact = 1'b1;
    step();
    chk("pre_arst_cork", 32'(txcork), 32'd0);
    rxval = 1'b1;
    rxdat = 8'hEE;
    repeat (3) step();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_cork", 32'(txcork), 32'd1);
    chk("arst_len", 32'(txlen), 32'd0);
    chk("arst_txdat", 32'(txdat), 32'd0);
    chk("arst_out_empty", 32'(out_empty), 32'hF);
    chk("arst_in_full", 32'(in_full), 32'd0);
    chk("arst_alter", 32'(inf_alter), 32'd0);
    rxval = 1'b0;
    rxact = 1'b0;
    in_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    out_pkt(1, 4, 8'hC0, 1'b1);
    read_out(0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
